// File: rtl/fp_adder_stage2_if.sv
// Stage-2 adder handshake and data bundle. The master side is the stage-1 driver
// and downstream sink. The slave side is the fp_adder_stage2 datapath.
interface fp_adder_stage2_if #(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int SIGNIFICAND_WIDTH = 23
);
  localparam int SW = SIGNIFICAND_WIDTH + 3;

  logic                      valid_i;
  logic                      stall_i;
  logic [5:0]                operand_align_shift_i;
  logic [SW-1:0]             significand1_i;
  logic [SW-1:0]             significand2_i;
  logic [EXPONENT_WIDTH-1:0] exponent1_i;
  logic [EXPONENT_WIDTH-1:0] exponent2_i;
  logic                      exponent2_larger_i;
  logic                      result_is_inf_i;
  logic                      result_is_nan_i;

  logic                      valid_o;
  logic [SW-1:0]             sum_o;
  logic [EXPONENT_WIDTH-1:0] exponent_o;
  logic                      sticky_o;
  logic                      result_is_inf_o;
  logic                      result_is_nan_o;

  modport master (
    output valid_i, stall_i, operand_align_shift_i, significand1_i, significand2_i,
           exponent1_i, exponent2_i, exponent2_larger_i, result_is_inf_i, result_is_nan_i,
    input  valid_o, sum_o, exponent_o, sticky_o, result_is_inf_o, result_is_nan_o
  );

  modport slave (
    input  valid_i, stall_i, operand_align_shift_i, significand1_i, significand2_i,
           exponent1_i, exponent2_i, exponent2_larger_i, result_is_inf_i, result_is_nan_i,
    output valid_o, sum_o, exponent_o, sticky_o, result_is_inf_o, result_is_nan_o
  );
endinterface

// File: rtl/fp_adder_stage2.sv
// FP adder stage 2: align the smaller significand, add, and register the raw sum,
// exponent, sticky and special flags. stall_i freezes every output register.
module fp_adder_stage2 #(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int SIGNIFICAND_WIDTH = 23
) (
  input logic              clk,
  input logic              reset,
  fp_adder_stage2_if.slave io
);
  localparam int SW = SIGNIFICAND_WIDTH + 3;

  logic [SW-1:0]             aligned2;
  logic [SW-1:0]             lost_mask;
  logic                      sticky;

  logic                      valid_d,  valid_q;
  logic [SW-1:0]             sum_d,    sum_q;
  logic [EXPONENT_WIDTH-1:0] exp_d,    exp_q;
  logic                      sticky_d, sticky_q;
  logic                      inf_d,    inf_q;
  logic                      nan_d,    nan_q;

  // Saturated shifts keep only sign fill, and every input bit counts as lost.
  always_comb begin
    aligned2  = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    if (32'(io.operand_align_shift_i) >= SW) begin
      aligned2 = {SW{io.significand2_i[SW-1]}};
      sticky   = |io.significand2_i;
    end else begin
      aligned2  = SW'($signed(io.significand2_i) >>> io.operand_align_shift_i);
      lost_mask = ~({SW{1'b1}} << io.operand_align_shift_i);
      sticky    = |(io.significand2_i & lost_mask);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    sum_d    = sum_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    inf_d    = inf_q;
    nan_d    = nan_q;
    if (!io.stall_i) begin
      valid_d  = io.valid_i;
      sum_d    = io.significand1_i + aligned2;
      exp_d    = io.exponent2_larger_i ? io.exponent2_i : io.exponent1_i;
      sticky_d = sticky;
      inf_d    = io.result_is_inf_i;
      nan_d    = io.result_is_nan_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      sum_q    <= '0;
      exp_q    <= '0;
      sticky_q <= 1'b0;
      inf_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sum_q    <= sum_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
      inf_q    <= inf_d;
      nan_q    <= nan_d;
    end
  end

  assign io.valid_o         = valid_q;
  assign io.sum_o           = sum_q;
  assign io.exponent_o      = exp_q;
  assign io.sticky_o        = sticky_q;
  assign io.result_is_inf_o = inf_q;
  assign io.result_is_nan_o = nan_q;
endmodule

// File: tb/tb_fp_adder_stage2.sv
// Directed bench for fp_adder_stage2: vector table plus stall and async-reset sequences.
module tb_fp_adder_stage2;
  localparam int EW = 8;
  localparam int SW = 26;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_adder_stage2_if #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(23)) io ();
  fp_adder_stage2 #(.EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(23)) dut (
    .clk(clk), .reset(reset), .io(io.slave));

  typedef struct {
    string         name;
    logic [5:0]    shift;
    logic [SW-1:0] sig1, sig2;
    logic [EW-1:0] exp1, exp2;
    logic          e2l, inf, nan;
    logic [SW-1:0] exp_sum;
    logic [EW-1:0] exp_exp;
    logic          exp_sticky;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [5:0] sh,
                       input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                       input logic [EW-1:0] e1, input logic [EW-1:0] e2,
                       input logic e2l, input logic inf, input logic nan);
    io.valid_i = v; io.stall_i = st; io.operand_align_shift_i = sh;
    io.significand1_i = s1; io.significand2_i = s2;
    io.exponent1_i = e1; io.exponent2_i = e2; io.exponent2_larger_i = e2l;
    io.result_is_inf_i = inf; io.result_is_nan_i = nan;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [SW-1:0] s,
                         input logic [EW-1:0] e, input logic st, input logic inf, input logic nan);
    chk({tag, ".valid"},  64'(io.valid_o), 64'(v));
    chk({tag, ".sum"},    64'(io.sum_o), 64'(s));
    chk({tag, ".exp"},    64'(io.exponent_o), 64'(e));
    chk({tag, ".sticky"}, 64'(io.sticky_o), 64'(st));
    chk({tag, ".inf"},    64'(io.result_is_inf_o), 64'(inf));
    chk({tag, ".nan"},    64'(io.result_is_nan_o), 64'(nan));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{"one_plus_one", 6'd0,  26'h0800000, 26'h0800000, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 26'h1000000, 8'h7F, 1'b0};
    vecs[1] = '{"one_minus_half", 6'd1, 26'h0800000, 26'h3800000, 8'h7F, 8'h7E, 1'b0, 1'b0, 1'b0, 26'h0400000, 8'h7F, 1'b0};
    vecs[2] = '{"sat_pos",        6'd30, 26'h0800000, 26'h0800001, 8'h80, 8'h62, 1'b0, 1'b0, 1'b0, 26'h0800000, 8'h80, 1'b1};
    vecs[3] = '{"sat_neg",        6'd30, 26'h0800000, 26'h37FFFFF, 8'h80, 8'h62, 1'b0, 1'b0, 1'b0, 26'h07FFFFF, 8'h80, 1'b1};
    vecs[4] = '{"sticky_set",     6'd2,  26'h0000000, 26'h0800003, 8'h10, 8'h12, 1'b1, 1'b0, 1'b0, 26'h0200000, 8'h12, 1'b1};
    vecs[5] = '{"sticky_clear",   6'd2,  26'h0000000, 26'h0800004, 8'h10, 8'h12, 1'b1, 1'b0, 1'b0, 26'h0200001, 8'h12, 1'b0};
    // shift SW-1 on the most negative value leaves all ones, nothing nonzero lost
    vecs[6] = '{"shift_sw_m1",    6'd25, 26'h0000001, 26'h2000000, 8'h40, 8'h20, 1'b0, 1'b0, 1'b0, 26'h0000000, 8'h40, 1'b0};
    vecs[7] = '{"shift_eq_sw_0",  6'd26, 26'h0123456, 26'h0000000, 8'h40, 8'h20, 1'b0, 1'b1, 1'b0, 26'h0123456, 8'h40, 1'b0};
    vecs[8] = '{"neg_shift0",     6'd0,  26'h0800000, 26'h3FFFFFF, 8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 26'h07FFFFF, 8'h02, 1'b0};

    drive(1'b0, 1'b0, 6'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #12;
    chk_all("reset_state", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, vecs[i].shift, vecs[i].sig1, vecs[i].sig2, vecs[i].exp1,
            vecs[i].exp2, vecs[i].e2l, vecs[i].inf, vecs[i].nan);
      tick();
      chk_all(vecs[i].name, 1'b1, vecs[i].exp_sum, vecs[i].exp_exp, vecs[i].exp_sticky,
              vecs[i].inf, vecs[i].nan);
    end

    // Op A loaded, then op B held off by three stalled edges.
    @(negedge clk);
    drive(1'b1, 1'b0, 6'd0, 26'h0000100, 26'h0000023, 8'h33, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("stall_a", 1'b1, 26'h0000123, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 6'd4, 26'h0001000, 26'h000001F, 8'h21, 8'h55, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all("stall_hold", 1'b1, 26'h0000123, 8'h33, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); io.stall_i = 1'b0;
    tick();
    chk_all("stall_b", 1'b1, 26'h0001001, 8'h55, 1'b1, 1'b1, 1'b0);

    // Async reset mid-cycle, overlapping stall: reset wins and clears immediately.
    io.stall_i = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("reset_over_edge", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b0;
    drive(1'b1, 1'b1, 6'd0, 26'h0000010, 26'h0000001, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("stalled_after_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); io.stall_i = 1'b0;
    tick();
    chk_all("nan_flag", 1'b1, 26'h0000011, 8'hFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk); io.valid_i = 1'b0;
    tick();
    chk("bubble.valid", 64'(io.valid_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_adder_stage2.md
# fp_adder_stage2

Second stage of the floating-point adder pipeline. Consumes the swapped two's-complement significands, alignment shift amount, exponents and special-case flags produced by the first adder stage. Arithmetically right-shifts the smaller-exponent significand, adds the two significands, and registers the raw two's-complement sum, the result exponent, a sticky bit and the inf/nan flags for the normalization stage. Adds a valid/stall pipeline handshake so that back-pressure from downstream holds the stage.

## Interface
Parameters:
- EXPONENT_WIDTH, 8, exponent field width
- SIGNIFICAND_WIDTH, 23, stored significand width (no hidden bit)

Ports (SW = SIGNIFICAND_WIDTH + 3):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  stage-1 registers hold a live operation
- stall_i  in  1  downstream cannot accept; hold outputs
- operand_align_shift_i  in  6  right-shift amount for significand2_i
- significand1_i  in  SW  larger-exponent significand, two's complement
- significand2_i  in  SW  smaller-exponent significand, two's complement
- exponent1_i  in  EXPONENT_WIDTH  operand 1 biased exponent
- exponent2_i  in  EXPONENT_WIDTH  operand 2 biased exponent
- exponent2_larger_i  in  1  exponent2_i > exponent1_i
- result_is_inf_i  in  1  special-case infinity
- result_is_nan_i  in  1  special-case NaN
- valid_o  out  1  outputs hold a live result
- sum_o  out  SW  two's-complement sum, unnormalized
- exponent_o  out  EXPONENT_WIDTH  result exponent before normalization
- sticky_o  out  1  nonzero bits lost in alignment
- result_is_inf_o  out  1  registered copy of result_is_inf_i
- result_is_nan_o  out  1  registered copy of result_is_nan_i

## Operation
- Alignment: aligned2 = significand2_i >>> operand_align_shift_i, arithmetic shift with sign fill from bit SW-1.
- Shift saturation: if the shift is >= SW, aligned2 is all sign bits: 0 for non-negative, all ones for negative.
- Sticky: OR of every bit shifted out of significand2_i.
  - If the shift is >= SW, sticky is the OR of all SW input bits.
  - If the shift is 0, sticky is 0.
- Sum: sum = significand1_i + aligned2, computed modulo 2^SW. The two leading zero bits of the stage-1 encoding give headroom, so no carry is kept beyond SW bits.
- Exponent: exponent_o = exponent2_larger_i ? exponent2_i : exponent1_i.
- Flags: inf/nan pass through unchanged. If both are set, both are forwarded; downstream gives NaN priority.
- Data registers load only when stall_i = 0. Loading is independent of valid_i, so bubbles carry don't-care data.

## Timing
- Latency: 1 cycle. Inputs sampled on edge N appear on the outputs after edge N.
- valid_o handshake:
  - stall_i = 0: valid_o <= valid_i on each edge.
  - stall_i = 1: all outputs, including valid_o, hold their previous values. Upstream is responsible for holding its own inputs.
- Reset values (asserted asynchronously, take effect immediately, no clock needed): valid_o = 0, sum_o = 0, exponent_o = 0, sticky_o = 0, result_is_inf_o = 0, result_is_nan_o = 0.
- Reset while stalled or mid-stream: all outputs clear; the in-flight operation is discarded.
- First capture after deassert: the first rising edge with reset = 0 and stall_i = 0.
- reset and stall_i high together: reset wins.

## Test plan
- 1.0 + 1.0
  - Stimulus: sig1 = sig2 = 0x0800000, shift 0, exp1 = exp2 = 0x7F, valid_i = 1.
  - Next cycle: sum_o = 0x1000000, exponent_o = 0x7F, sticky_o = 0, valid_o = 1.
- 1.0 - 0.5
  - Stimulus: sig1 = 0x0800000, sig2 = 0x3800000, shift 1, exp1 = 0x7F, exp2 = 0x7E, exponent2_larger_i = 0.
  - Next cycle: sum_o = 0x0400000, exponent_o = 0x7F, sticky_o = 0.
- Saturated shift
  - Stimulus: shift 30, sig1 = 0x0800000.
  - sig2 = 0x0800001: sum_o = 0x0800000, sticky_o = 1.
  - sig2 = 0x37FFFFF (negative): aligned2 = 0x3FFFFFF, sum_o = 0x07FFFFF, sticky_o = 1.
- Sticky on partial shift
  - Stimulus: sig2 = 0x0800003, shift 2, sig1 = 0.
  - Next cycle: sum_o = 0x0200000, sticky_o = 1.
  - Repeat with sig2 = 0x0800004: sum_o = 0x0200001, sticky_o = 0.
- Stall
  - Present op A, then raise stall_i for 3 cycles while presenting op B.
  - Outputs stay equal to A with valid_o = 1 throughout the stall.
  - First edge after stall_i drops: outputs show B.
  - With valid_i = 0 and stall_i = 0, valid_o = 0 next cycle.
- Async reset and flags
  - Assert reset mid-cycle while valid_o = 1: all outputs go to 0 immediately, before any clock edge.
  - After release: result_is_nan_i = 1 with exponent2_larger_i = 1 and exp2 = 0xFF gives result_is_nan_o = 1, exponent_o = 0xFF.
